// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - checks a CPU's store stream against a table of expected writes
//
// Purpose: a DEPTH-entry table of expected (address, data) stores is loaded
// while idle. A run (start) then walks the table in order: every memwrite
// must match the current entry, a match on the last entry passes, and a run
// that lasts TIMEOUT-1 RUN cycles fails with timeout set.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      begin/restart a run (ignored while running)
//   memwrite, aluout,
//   writedata                  store strobe, address and data from the CPU
//   exp_we, exp_idx,
//   exp_addr, exp_data         table write port (honoured only in IDLE)
//   exp_count                  number of entries to check, latched on start
//   busy, done, pass, fail,
//   timeout                    run status
//   match_count                expected writes matched so far
//   fail_idx                   table entry being checked when the run failed
//   cycles                     RUN cycles elapsed (saturating)
//
// Configuration macro: MEM_WRITE_CHECKER_SKIP_UNMATCHED_EN
//   defined   - stores that do not match the current entry are skipped;
//               only the timeout can fail a run
//   undefined - any non-matching store fails the run
module mem_write_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1000,
    parameter int CW      = 16,
    localparam int IW     = $clog2(DEPTH),
    localparam int NW     = IW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] aluout,
    input  logic [WIDTH-1:0] writedata,
    input  logic             exp_we,
    input  logic [IW-1:0]    exp_idx,
    input  logic [WIDTH-1:0] exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    input  logic [NW-1:0]    exp_count,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [NW-1:0]    match_count,
    output logic [IW-1:0]    fail_idx,
    output logic [CW-1:0]    cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam logic [CW-1:0] CYC_MAX = '1;
    localparam logic [31:0]   TMO_LIM = 32'(TIMEOUT - 1);

    state_t          state, state_n;
    logic [NW-1:0]   ptr, ptr_n;
    logic [NW-1:0]   count_q, count_n;
    logic [NW-1:0]   match_count_n;
    logic [IW-1:0]   fail_idx_n;
    logic [CW-1:0]   cycles_n;
    logic            timeout_n;

    logic [WIDTH-1:0] addr_tab [DEPTH];
    logic [WIDTH-1:0] data_tab [DEPTH];

    logic [CW-1:0]   cyc_inc;
    logic            hit;
    logic            last;
    logic            tmo_hit;
    logic            pass_now;

    // Table is deliberately not reset so a run can be repeated after reset.
    always_ff @(posedge clk) begin
        if (!reset && state == IDLE && exp_we) begin
            addr_tab[exp_idx] <= exp_addr;
            data_tab[exp_idx] <= exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            count_q     <= '0;
            match_count <= '0;
            fail_idx    <= '0;
            cycles      <= '0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            count_q     <= count_n;
            match_count <= match_count_n;
            fail_idx    <= fail_idx_n;
            cycles      <= cycles_n;
            timeout     <= timeout_n;
        end
    end

    always_comb begin
        state_n       = state;
        ptr_n         = ptr;
        count_n       = count_q;
        match_count_n = match_count;
        fail_idx_n    = fail_idx;
        cycles_n      = cycles;
        timeout_n     = timeout;
        pass_now      = 1'b0;

        cyc_inc = (cycles == CYC_MAX) ? cycles : cycles + CW'(1);
        hit     = (aluout == addr_tab[ptr[IW-1:0]]) &&
                  (writedata == data_tab[ptr[IW-1:0]]);
        last    = (ptr + NW'(1) == count_q);
        // Timeout is judged on the value cycles takes at this edge.
        tmo_hit = (32'(cyc_inc) >= TMO_LIM);

        case (state)
            RUN: begin
                cycles_n = cyc_inc;
                if (count_q == '0) begin
                    pass_now = 1'b1;
                end else if (memwrite && hit) begin
                    ptr_n         = ptr + NW'(1);
                    match_count_n = match_count + NW'(1);
                    pass_now      = last;
                end else if (memwrite) begin
`ifndef MEM_WRITE_CHECKER_SKIP_UNMATCHED_EN
                    state_n    = FAIL;
                    fail_idx_n = ptr[IW-1:0];
`endif
                end

                // A final match beats a simultaneous timeout.
                if (pass_now) begin
                    state_n = PASS;
                end else if (tmo_hit) begin
                    state_n    = FAIL;
                    timeout_n  = 1'b1;
                    fail_idx_n = ptr_n[IW-1:0];
                end
            end
            default: begin
                if (start) begin
                    state_n       = RUN;
                    ptr_n         = '0;
                    count_n       = exp_count;
                    match_count_n = '0;
                    fail_idx_n    = '0;
                    cycles_n      = '0;
                    timeout_n     = 1'b0;
                end
            end
        endcase
    end

    assign busy = (state == RUN);
    assign pass = (state == PASS);
    assign fail = (state == FAIL);
    assign done = pass || fail;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb/tb_mem_write_checker.sv - directed vector bench for mem_write_checker
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0, start = 1'b0, memwrite = 1'b0, exp_we = 1'b0;
    logic [31:0] aluout = '0, writedata = '0, exp_addr = '0, exp_data = '0;
    logic [2:0]  exp_idx = '0;
    logic [3:0]  exp_count = '0;

    logic        busy, done, pass, fail, timeout;
    logic [3:0]  match_count;
    logic [2:0]  fail_idx;
    logic [15:0] cycles;

    logic        busy8, done8, pass8, fail8, timeout8;
    logic [3:0]  match_count8;
    logic [2:0]  fail_idx8;
    logic [15:0] cycles8;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_write_checker #(.WIDTH(32), .DEPTH(8), .TIMEOUT(16), .CW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .memwrite(memwrite),
        .aluout(aluout), .writedata(writedata), .exp_we(exp_we),
        .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
        .exp_count(exp_count), .busy(busy), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .match_count(match_count),
        .fail_idx(fail_idx), .cycles(cycles)
    );

    mem_write_checker #(.WIDTH(32), .DEPTH(8), .TIMEOUT(8), .CW(16)) dut8 (
        .clk(clk), .reset(reset), .start(start), .memwrite(memwrite),
        .aluout(aluout), .writedata(writedata), .exp_we(exp_we),
        .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
        .exp_count(exp_count), .busy(busy8), .done(done8), .pass(pass8),
        .fail(fail8), .timeout(timeout8), .match_count(match_count8),
        .fail_idx(fail_idx8), .cycles(cycles8)
    );

    // status = {busy, done, pass, fail, timeout}
    typedef struct {
        string       name;
        logic        rst, st, mw;
        logic [31:0] a, d;
        logic [3:0]  ec;
        logic [4:0]  status;
        logic [3:0]  mc;
        logic [2:0]  fidx;
        logic [15:0] cyc;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(string n, logic r, logic s, logic m,
                                logic [31:0] a, logic [31:0] d, logic [3:0] ec,
                                logic [4:0] stat, logic [3:0] mc,
                                logic [2:0] fi, logic [15:0] cy);
        vec_t v;
        v.name = n; v.rst = r; v.st = s; v.mw = m; v.a = a; v.d = d; v.ec = ec;
        v.status = stat; v.mc = mc; v.fidx = fi; v.cyc = cy;
        return v;
    endfunction

    task automatic check(string name, logic [27:0] act, logic [27:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; memwrite = 0; exp_we = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
        idle_inputs();
        exp_we = 1; exp_idx = idx[2:0]; exp_addr = a; exp_data = d;
        step();
        exp_we = 0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            reset = vecs[i].rst; start = vecs[i].st; memwrite = vecs[i].mw;
            aluout = vecs[i].a; writedata = vecs[i].d; exp_count = vecs[i].ec;
            step();
            check(vecs[i].name,
                  {busy, done, pass, fail, timeout, match_count, fail_idx, cycles},
                  {vecs[i].status, vecs[i].mc, vecs[i].fidx, vecs[i].cyc});
        end
        idle_inputs();
    endtask

    localparam logic [4:0] S0 = 5'b00000, SR = 5'b10000, SP = 5'b01100,
                           SF = 5'b01010, ST = 5'b01011;

    initial begin
        int n;
        // single-entry pass
        vecs[0]  = mk("reset_state",   1,0,0, 0,0,1, S0, 0,0,0);
        vecs[1]  = mk("start_1",       0,1,0, 0,0,1, SR, 0,0,0);
        vecs[2]  = mk("match_64_1",    0,0,1, 64,1,1, SP, 1,0,1);
        vecs[3]  = mk("pass_sticky",   0,0,0, 0,0,1, SP, 1,0,1);
        vecs[4]  = mk("mw_ignored_pass",0,0,1, 64,1,1, SP, 1,0,1);
        // three-entry run with a bad second store
        vecs[5]  = mk("start_3",       0,1,0, 0,0,3, SR, 0,0,0);
        vecs[6]  = mk("match_40_7",    0,0,1, 40,7,3, SR, 1,0,1);
`ifdef MEM_WRITE_CHECKER_SKIP_UNMATCHED_EN
        vecs[7]  = mk("skip_44_9",     0,0,1, 44,9,3, SR, 1,0,2);
        vecs[8]  = mk("match_44_5",    0,0,1, 44,5,3, SR, 2,0,3);
        vecs[9]  = mk("match_48_3",    0,0,1, 48,3,3, SP, 3,0,4);
`else
        vecs[7]  = mk("mismatch_44_9", 0,0,1, 44,9,3, SF, 1,1,2);
        vecs[8]  = mk("fail_sticky_a", 0,0,1, 44,5,3, SF, 1,1,2);
        vecs[9]  = mk("fail_sticky_b", 0,0,1, 48,3,3, SF, 1,1,2);
`endif
        // restart from PASS/FAIL, start ignored in RUN, reset mid-run
        vecs[10] = mk("restart",       0,1,0, 0,0,3, SR, 0,0,0);
        vecs[11] = mk("rerun_40_7",    0,0,1, 40,7,3, SR, 1,0,1);
        vecs[12] = mk("start_in_run",  0,1,0, 0,0,3, SR, 1,0,2);
        vecs[13] = mk("reset_mid_run", 1,0,0, 0,0,3, S0, 0,0,0);
        vecs[14] = mk("idle_after_rst",0,0,0, 0,0,3, S0, 0,0,0);
        vecs[15] = mk("start_retained",0,1,0, 0,0,3, SR, 0,0,0);
        vecs[16] = mk("ret_40_7",      0,0,1, 40,7,3, SR, 1,0,1);
        vecs[17] = mk("ret_44_5",      0,0,1, 44,5,3, SR, 2,0,2);
        vecs[18] = mk("ret_48_3",      0,0,1, 48,3,3, SP, 3,0,3);
        // zero-length run
        vecs[19] = mk("start_0",       0,1,0, 0,0,0, SR, 0,0,0);
        vecs[20] = mk("pass_count0",   0,0,0, 0,0,0, SP, 0,0,1);
        // reset priority over start, memwrite ignored in IDLE
        vecs[21] = mk("reset_over_st", 1,1,0, 0,0,1, S0, 0,0,0);
        vecs[22] = mk("still_idle",    0,0,0, 0,0,1, S0, 0,0,0);
        vecs[23] = mk("mw_in_idle",    0,0,1, 40,7,1, S0, 0,0,0);

        do_reset();
        load(0, 64, 1);
        run_vecs(0, 4);
        do_reset();
        load(0, 40, 7);
        load(1, 44, 5);
        load(2, 48, 3);
        run_vecs(5, 23);

        // exp_we outside IDLE must not disturb the table
        exp_count = 1; start = 1; step(); start = 0;
        exp_we = 1; exp_idx = 0; exp_addr = 99; exp_data = 99; step(); exp_we = 0;
        memwrite = 1; aluout = 40; writedata = 7; step(); memwrite = 0;
        check("we_ignored_run", {27'd0, pass}, 28'd1);

        // timeout with no stores (TIMEOUT=16)
        do_reset();
        exp_count = 1; start = 1; step(); start = 0;
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        check("timeout_edges", 28'(n), 28'd15);
        check("timeout_status",
              {busy, done, pass, fail, timeout, match_count, fail_idx, cycles},
              {ST, 4'd0, 3'd0, 16'd15});

        // final match on the timeout edge (TIMEOUT=8): pass wins
        do_reset();
        exp_count = 1; start = 1; step(); start = 0;
        repeat (6) step();
        check("race_pre_cycles", 28'(cycles8), 28'd6);
        memwrite = 1; aluout = 40; writedata = 7; step(); memwrite = 0;
        check("race_status",
              {busy8, done8, pass8, fail8, timeout8, match_count8, fail_idx8, cycles8},
              {SP, 4'd1, 3'd0, 16'd7});

        // second entry pending at timeout reports its index (TIMEOUT=8)
        do_reset();
        exp_count = 2; start = 1; step(); start = 0;
        memwrite = 1; aluout = 40; writedata = 7; step(); memwrite = 0;
        repeat (6) step();
        check("timeout_idx1",
              {busy8, done8, pass8, fail8, timeout8, match_count8, fail_idx8, cycles8},
              {ST, 4'd1, 3'd1, 16'd7});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter WIDTH, 32, width of the address and data buses.
REQ-002 Parameter DEPTH, 8, number of entries in the expected-write table.
REQ-003 Parameter TIMEOUT, 1000, RUN cycles allowed before a timeout fail.
REQ-004 Parameter CW, 16, width of the cycle counter.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  begin or restart a check run.
REQ-008 memwrite  in  1  store strobe from the CPU under test.
REQ-009 aluout  in  WIDTH  store address from the CPU.
REQ-010 writedata  in  WIDTH  store data from the CPU.
REQ-011 exp_we  in  1  write enable for one expected-table entry.
REQ-012 exp_idx  in  clog2(DEPTH)  index of the table entry being written.
REQ-013 exp_addr, exp_data  in  WIDTH each  expected store address and data.
REQ-014 exp_count  in  clog2(DEPTH)+1  number of table entries to check, 0..DEPTH; sampled when start is accepted.
REQ-015 busy, done, pass, fail, timeout  out  1 each  run status.
REQ-016 match_count  out  clog2(DEPTH)+1  number of expected writes matched so far.
REQ-017 fail_idx  out  clog2(DEPTH)  table index of the entry being checked when the fail occurred.
REQ-018 cycles  out  CW  number of RUN cycles elapsed.

Function
REQ-019 The block SHALL implement the states IDLE, RUN, PASS and FAIL.
REQ-020 In IDLE, exp_we SHALL write exp_addr and exp_data into table[exp_idx]; exp_we SHALL be ignored in every other state.
REQ-021 start in IDLE, PASS or FAIL SHALL enter RUN on the next edge:
  - ptr, match_count and cycles clear to 0;
  - exp_count is latched;
  - done, pass, fail and timeout clear.
  start SHALL be ignored while in RUN.
REQ-022 If the latched exp_count is 0, the block SHALL go from RUN to PASS on the first RUN edge.
REQ-023 RUN SHALL assert busy=1, and cycles SHALL increment on every RUN edge, saturating at 2^CW-1.
REQ-024 A match on memwrite=1 SHALL increment ptr and match_count on that edge. A match is aluout==table[ptr].addr and writedata==table[ptr].data.
REQ-025 A match where ptr==count-1 SHALL enter PASS on the same edge, with done=pass=1 visible the following cycle (one-cycle latency).
REQ-026 On a mismatching memwrite, the block SHALL enter FAIL with fail_idx=ptr, unless the configuration macro is defined (REQ-033).
REQ-027 When cycles reaches TIMEOUT-1 in RUN, the block SHALL enter FAIL with timeout=1 and fail_idx=ptr.
REQ-028 If a final match and the timeout occur on the same edge, PASS SHALL win and timeout SHALL stay 0.
REQ-029 PASS and FAIL SHALL be sticky: done=1, busy=0, and every counter holds until reset or start.
REQ-030 memwrite SHALL be ignored outside RUN; pass and fail SHALL never be 1 at the same time.

Reset
REQ-031 reset SHALL take priority over start, exp_we and every other input.
REQ-032 On any edge with reset=1, the block SHALL:
  - enter IDLE, including when reset arrives mid-run;
  - clear busy, done, pass, fail, timeout, match_count, fail_idx, cycles and ptr to 0;
  - leave the table contents unchanged.

Configuration
REQ-033 Macro MEM_WRITE_CHECKER_SKIP_UNMATCHED_EN:
  - When defined, a mismatching memwrite in RUN SHALL be ignored: no state change and ptr holds. Only timeout can cause FAIL.
  - When undefined, any mismatching memwrite SHALL cause FAIL per REQ-026.

Verification
REQ-034 Load table[0]=(64,1) with exp_count=1, start, then drive memwrite with aluout=64 and writedata=1 -> pass=1, done=1 and match_count=1 one cycle later; fail=0.
REQ-035 Load table[0..2]=(40,7),(44,5),(48,3), then drive stores (40,7),(44,9) -> fail=1 and fail_idx=1 after the second store (macro undefined); with the macro defined -> still RUN, and the later store (44,5),(48,3) gives pass=1.
REQ-036 TIMEOUT=16, exp_count=1, no memwrite -> fail=1, timeout=1 and cycles=15.
REQ-037 exp_count=0, start -> pass=1 one edge after RUN entry, cycles=1.
REQ-038 Assert reset for one cycle after one of three matches -> all outputs 0 and state IDLE; a following start with the same stores -> pass=1, proving the table was retained.
REQ-039 TIMEOUT=8 with the final matching store on the edge where cycles=7 -> pass=1 and timeout=0.
